// File: rtl/rv32i_types_pkg.sv
// Shared RV32I base types used across the pipeline.
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/tspp_trap_sequencer_pkg.sv
// Machine-mode trap types: cause codes, sequencer states and CSR helpers.
package tspp_trap_sequencer_pkg;
    import rv32i_types_pkg::*;

    typedef enum logic [4:0] {
        CAUSE_MAL_INSN   = 5'd0,
        CAUSE_FAULT_INSN = 5'd1,
        CAUSE_ILLEGAL    = 5'd2,
        CAUSE_BREAKPOINT = 5'd3,
        CAUSE_MAL_L      = 5'd4,
        CAUSE_FAULT_L    = 5'd5,
        CAUSE_MAL_S      = 5'd6,
        CAUSE_FAULT_S    = 5'd7,
        CAUSE_ENV_M      = 5'd11
    } ex_cause_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        INSERT = 2'd2
    } trap_state_t;

    // Illegal instructions and ecalls report no faulting address.
    function automatic logic cause_has_tval(input ex_cause_t cause);
        return !((cause == CAUSE_ILLEGAL) || (cause == CAUSE_ENV_M));
    endfunction

    function automatic word_t cause_word(input ex_cause_t cause);
        return {27'd0, cause};
    endfunction

endpackage

// File: rtl/tspp_trap_sequencer_if.sv
// Pipeline <-> trap sequencer bundle: exception inputs, CSR strobes, redirect outputs.
interface tspp_trap_sequencer_if;
    import rv32i_types_pkg::*;

    logic  token_ex;
    logic  mispredict;
    logic  fault_insn;
    logic  mal_insn;
    logic  illegal_insn;
    logic  breakpoint;
    logic  env_m;
    logic  mal_l;
    logic  mal_s;
    logic  fault_l;
    logic  fault_s;
    logic  ret;
    word_t epc_f;
    word_t epc_e;
    word_t badaddr_f;
    word_t badaddr_e;
    logic  i_mem_busy;
    logic  d_mem_busy;
    logic  csr_wr_mtvec;
    logic  csr_wr_mepc;
    word_t csr_wdata;
    word_t priv_pc;
    logic  insert_priv_pc;
    logic  trap_stall;
    logic  trap_flush;
    word_t mtvec;
    word_t mepc;
    word_t mcause;
    word_t mtval;

    modport master (
        output token_ex, mispredict, fault_insn, mal_insn, illegal_insn, breakpoint,
               env_m, mal_l, mal_s, fault_l, fault_s, ret, epc_f, epc_e, badaddr_f,
               badaddr_e, i_mem_busy, d_mem_busy, csr_wr_mtvec, csr_wr_mepc, csr_wdata,
        input  priv_pc, insert_priv_pc, trap_stall, trap_flush, mtvec, mepc, mcause, mtval
    );

    modport slave (
        input  token_ex, mispredict, fault_insn, mal_insn, illegal_insn, breakpoint,
               env_m, mal_l, mal_s, fault_l, fault_s, ret, epc_f, epc_e, badaddr_f,
               badaddr_e, i_mem_busy, d_mem_busy, csr_wr_mtvec, csr_wr_mepc, csr_wdata,
        output priv_pc, insert_priv_pc, trap_stall, trap_flush, mtvec, mepc, mcause, mtval
    );

endinterface

// File: rtl/tspp_trap_prio_enc.sv
// Combinational trap priority encoder: execute exceptions first, then unsquashed fetch exceptions.
module tspp_trap_prio_enc
    import tspp_trap_sequencer_pkg::*;
(
    input  logic      token_ex,
    input  logic      mispredict,
    input  logic      fault_insn,
    input  logic      mal_insn,
    input  logic      illegal_insn,
    input  logic      breakpoint,
    input  logic      env_m,
    input  logic      mal_l,
    input  logic      mal_s,
    input  logic      fault_l,
    input  logic      fault_s,
    output logic      valid,
    output ex_cause_t cause,
    output logic      from_fetch
);

    // Fixed-priority select; a mispredict marks the fetch slot as wrong-path.
    always_comb begin
        valid      = 1'b1;
        cause      = CAUSE_MAL_INSN;
        from_fetch = 1'b0;
        if (token_ex && illegal_insn) begin
            cause = CAUSE_ILLEGAL;
        end else if (token_ex && breakpoint) begin
            cause = CAUSE_BREAKPOINT;
        end else if (token_ex && env_m) begin
            cause = CAUSE_ENV_M;
        end else if (token_ex && mal_l) begin
            cause = CAUSE_MAL_L;
        end else if (token_ex && mal_s) begin
            cause = CAUSE_MAL_S;
        end else if (token_ex && fault_l) begin
            cause = CAUSE_FAULT_L;
        end else if (token_ex && fault_s) begin
            cause = CAUSE_FAULT_S;
        end else if (!mispredict && mal_insn) begin
            cause      = CAUSE_MAL_INSN;
            from_fetch = 1'b1;
        end else if (!mispredict && fault_insn) begin
            cause      = CAUSE_FAULT_INSN;
            from_fetch = 1'b1;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/tspp_trap_sequencer.sv
// Trap / MRET sequencer: captures mepc/mcause/mtval, drains memory, then requests a PC insert.
// Optional macro TSPP_TRAP_TVAL_EN keeps the mtval register; otherwise mtval reads as zero.
module tspp_trap_sequencer
    import rv32i_types_pkg::*;
    import tspp_trap_sequencer_pkg::*;
#(
    parameter word_t MTVEC_RST = 32'h0000_0100,
    parameter word_t MEPC_RST  = 32'h0000_0000
) (
    input logic                  CLK,
    input logic                  nRST,
    tspp_trap_sequencer_if.slave bus
);

    localparam word_t MTVEC_RST_ALIGNED = {MTVEC_RST[31:2], 2'b00};

    trap_state_t state_r, state_n;
    logic        is_mret_r;
    word_t       mtvec_r, mtvec_n_s;
    word_t       mepc_r, mepc_n_s;
    word_t       mcause_r, mcause_n_s;
    word_t       priv_pc_r, target_s;
    logic        insert_r, stall_r, flush_r;
    logic        exc_valid_s, exc_fetch_s;
    ex_cause_t   exc_cause_s;
    logic        trap_start_s, mret_start_s;

    tspp_trap_prio_enc u_prio (
        .token_ex     (bus.token_ex),
        .mispredict   (bus.mispredict),
        .fault_insn   (bus.fault_insn),
        .mal_insn     (bus.mal_insn),
        .illegal_insn (bus.illegal_insn),
        .breakpoint   (bus.breakpoint),
        .env_m        (bus.env_m),
        .mal_l        (bus.mal_l),
        .mal_s        (bus.mal_s),
        .fault_l      (bus.fault_l),
        .fault_s      (bus.fault_s),
        .valid        (exc_valid_s),
        .cause        (exc_cause_s),
        .from_fetch   (exc_fetch_s)
    );

    assign trap_start_s = (state_r == IDLE) && exc_valid_s;
    assign mret_start_s = (state_r == IDLE) && !exc_valid_s && bus.ret && bus.token_ex;

    // Next-state logic; events outside IDLE are ignored since the pipeline is frozen.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (trap_start_s || mret_start_s) state_n = DRAIN;
                else                              state_n = IDLE;
            end
            DRAIN: begin
                if (bus.i_mem_busy || bus.d_mem_busy) state_n = DRAIN;
                else                                  state_n = INSERT;
            end
            INSERT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // CSR next values; a trap capture takes precedence over a software mepc write.
    always_comb begin
        mtvec_n_s  = mtvec_r;
        mepc_n_s   = mepc_r;
        mcause_n_s = mcause_r;
        if (bus.csr_wr_mtvec) mtvec_n_s = {bus.csr_wdata[31:2], 2'b00};
        else                  mtvec_n_s = mtvec_r;
        if (trap_start_s) begin
            mepc_n_s   = (exc_fetch_s ? bus.epc_f : bus.epc_e) & ~32'h0000_0001;
            mcause_n_s = cause_word(exc_cause_s);
        end else if (bus.csr_wr_mepc) begin
            mepc_n_s = {bus.csr_wdata[31:1], 1'b0};
        end else begin
            mepc_n_s   = mepc_r;
            mcause_n_s = mcause_r;
        end
        // Next values so that a write landing on the INSERT edge is the target.
        target_s = is_mret_r ? mepc_n_s : mtvec_n_s;
    end

    // State, CSR and registered redirect outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r   <= IDLE;
            is_mret_r <= 1'b0;
            mtvec_r   <= MTVEC_RST_ALIGNED;
            mepc_r    <= MEPC_RST;
            mcause_r  <= 32'h0000_0000;
            priv_pc_r <= 32'h0000_0000;
            insert_r  <= 1'b0;
            stall_r   <= 1'b0;
            flush_r   <= 1'b0;
        end else begin
            state_r  <= state_n;
            mtvec_r  <= mtvec_n_s;
            mepc_r   <= mepc_n_s;
            mcause_r <= mcause_n_s;
            if (trap_start_s || mret_start_s) is_mret_r <= mret_start_s;
            else                              is_mret_r <= is_mret_r;
            if (state_n == INSERT) priv_pc_r <= target_s;
            else                   priv_pc_r <= priv_pc_r;
            insert_r <= (state_n == INSERT);
            flush_r  <= (state_n == INSERT);
            stall_r  <= (state_n == DRAIN);
        end
    end

`ifdef TSPP_TRAP_TVAL_EN
    word_t mtval_r;

    // Faulting address capture, zero for causes without one.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mtval_r <= 32'h0000_0000;
        end else if (trap_start_s) begin
            if (cause_has_tval(exc_cause_s))
                mtval_r <= exc_fetch_s ? bus.badaddr_f : bus.badaddr_e;
            else
                mtval_r <= 32'h0000_0000;
        end else begin
            mtval_r <= mtval_r;
        end
    end

    assign bus.mtval = mtval_r;
`else
    assign bus.mtval = 32'h0000_0000;
`endif

    assign bus.priv_pc        = priv_pc_r;
    assign bus.insert_priv_pc = insert_r;
    assign bus.trap_stall     = stall_r;
    assign bus.trap_flush     = flush_r;
    assign bus.mtvec          = mtvec_r;
    assign bus.mepc           = mepc_r;
    assign bus.mcause         = mcause_r;

endmodule

// File: tb/tb_tspp_trap_sequencer.sv
// Self-checking bench for tspp_trap_sequencer against a cycle-level behavioural model.
module tb_tspp_trap_sequencer;

`ifdef TSPP_TRAP_TVAL_EN
    localparam bit TVAL_EN = 1'b1;
`else
    localparam bit TVAL_EN = 1'b0;
`endif

    typedef struct {
        logic        token_ex, mispredict, fault_insn, mal_insn, illegal_insn, breakpoint;
        logic        env_m, mal_l, mal_s, fault_l, fault_s, ret, csr_wr_mepc;
        logic [31:0] epc_f, epc_e, badaddr_f, badaddr_e, csr_wdata;
    } ev_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_priv;

    tspp_trap_sequencer_if bus ();
    tspp_trap_sequencer dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    always #5 CLK = ~CLK;

    function automatic ev_t ev_zero();
        ev_t e;
        e.token_ex = 0; e.mispredict = 0; e.fault_insn = 0; e.mal_insn = 0;
        e.illegal_insn = 0; e.breakpoint = 0; e.env_m = 0; e.mal_l = 0; e.mal_s = 0;
        e.fault_l = 0; e.fault_s = 0; e.ret = 0; e.csr_wr_mepc = 0;
        e.epc_f = 0; e.epc_e = 0; e.badaddr_f = 0; e.badaddr_e = 0; e.csr_wdata = 0;
        return e;
    endfunction

    task automatic drive_ev(input ev_t e);
        bus.token_ex = e.token_ex; bus.mispredict = e.mispredict;
        bus.fault_insn = e.fault_insn; bus.mal_insn = e.mal_insn;
        bus.illegal_insn = e.illegal_insn; bus.breakpoint = e.breakpoint;
        bus.env_m = e.env_m; bus.mal_l = e.mal_l; bus.mal_s = e.mal_s;
        bus.fault_l = e.fault_l; bus.fault_s = e.fault_s; bus.ret = e.ret;
        bus.csr_wr_mepc = e.csr_wr_mepc; bus.csr_wdata = e.csr_wdata;
        bus.epc_f = e.epc_f; bus.epc_e = e.epc_e;
        bus.badaddr_f = e.badaddr_f; bus.badaddr_e = e.badaddr_e;
    endtask

    // Architectural priority rules written as an ordered table.
    function automatic void model(input ev_t e, output bit take, output bit mret,
                                  output int cause, output bit fetch);
        int  codes [7] = '{2, 3, 11, 4, 6, 5, 7};
        bit  flags [7];
        flags = '{e.illegal_insn, e.breakpoint, e.env_m, e.mal_l, e.mal_s, e.fault_l, e.fault_s};
        take = 0; mret = 0; cause = 0; fetch = 0;
        for (int i = 0; i < 7; i++)
            if (!take && e.token_ex && flags[i]) begin take = 1; cause = codes[i]; end
        if (!take && !e.mispredict && (e.mal_insn || e.fault_insn)) begin
            take = 1; fetch = 1; cause = e.mal_insn ? 0 : 1;
        end
        mret = !take && e.ret && e.token_ex;
    endfunction

    task automatic model_reset();
        m_mtvec = 32'h0000_0100; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_priv = 0;
    endtask

    task automatic csr_write(input bit to_mtvec, input logic [31:0] data);
        bus.csr_wr_mtvec = to_mtvec; bus.csr_wr_mepc = !to_mtvec; bus.csr_wdata = data;
        @(posedge CLK); #1;
        bus.csr_wr_mtvec = 0; bus.csr_wr_mepc = 0;
        if (to_mtvec) m_mtvec = {data[31:2], 2'b00};
        else          m_mepc  = {data[31:1], 1'b0};
        n_checks++;
        if (bus.mtvec !== m_mtvec || bus.mepc !== m_mepc) begin
            n_fail++;
            $display("FAIL csr_write: mtvec=%h mepc=%h required mtvec=%h mepc=%h",
                     bus.mtvec, bus.mepc, m_mtvec, m_mepc);
        end
    endtask

    // One event in IDLE, then follow the whole drain/insert sequence.
    task automatic do_event(input string name, input ev_t e, input int busy, input bit use_i,
                            input bit mtvec_wr, input logic [31:0] mtvec_val, input bit inject);
        bit take, mret, fetch;
        int cause, stalls, exp_stalls;
        logic [31:0] target;
        model(e, take, mret, cause, fetch);
        drive_ev(e);
        bus.i_mem_busy = use_i && (busy > 0);
        bus.d_mem_busy = !use_i && (busy > 0);
        @(posedge CLK); #1;
        drive_ev(ev_zero());
        bus.i_mem_busy = use_i && (busy > 1);
        bus.d_mem_busy = !use_i && (busy > 1);
        if (take) begin
            m_mepc = (fetch ? e.epc_f : e.epc_e) & ~32'h1;
            m_mcause = cause;
            m_mtval = (TVAL_EN && cause != 2 && cause != 11) ? (fetch ? e.badaddr_f : e.badaddr_e) : 32'h0;
        end else if (e.csr_wr_mepc) begin
            m_mepc = {e.csr_wdata[31:1], 1'b0};
        end
        n_checks++;
        if (bus.mcause !== m_mcause || bus.mepc !== m_mepc || bus.mtval !== m_mtval || bus.mtvec !== m_mtvec) begin
            n_fail++;
            $display("FAIL %s csr: mcause=%h mepc=%h mtval=%h mtvec=%h required %h %h %h %h", name,
                     bus.mcause, bus.mepc, bus.mtval, bus.mtvec, m_mcause, m_mepc, m_mtval, m_mtvec);
        end
        if (!(take || mret)) begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (bus.trap_stall !== 1'b0 || bus.insert_priv_pc !== 1'b0 || bus.priv_pc !== m_priv) begin
                    n_fail++;
                    $display("FAIL %s idle: stall=%b insert=%b priv_pc=%h required 0 0 %h",
                             name, bus.trap_stall, bus.insert_priv_pc, bus.priv_pc, m_priv);
                end
                @(posedge CLK); #1;
            end
            bus.i_mem_busy = 0; bus.d_mem_busy = 0;
            return;
        end
        stalls = 0;
        while (bus.trap_stall === 1'b1 && stalls < 64) begin
            stalls++;
            if (stalls == 1 && mtvec_wr) begin bus.csr_wr_mtvec = 1; bus.csr_wdata = mtvec_val; end
            if (stalls == 1 && inject) begin
                bus.token_ex = 1; bus.illegal_insn = 1; bus.ret = 1; bus.epc_e = $urandom;
            end
            @(posedge CLK); #1;
            drive_ev(ev_zero());
            bus.csr_wr_mtvec = 0;
            bus.i_mem_busy = use_i && (busy > stalls + 1);
            bus.d_mem_busy = !use_i && (busy > stalls + 1);
        end
        if (mtvec_wr) m_mtvec = {mtvec_val[31:2], 2'b00};
        target = mret ? m_mepc : m_mtvec;
        exp_stalls = (busy < 1) ? 1 : busy;
        n_checks++;
        if (stalls != exp_stalls) begin
            n_fail++;
            $display("FAIL %s stall_len: got %0d cycles required %0d", name, stalls, exp_stalls);
        end
        n_checks++;
        if (bus.insert_priv_pc !== 1'b1 || bus.trap_flush !== 1'b1 || bus.priv_pc !== target) begin
            n_fail++;
            $display("FAIL %s insert: insert=%b flush=%b priv_pc=%h required 1 1 %h",
                     name, bus.insert_priv_pc, bus.trap_flush, bus.priv_pc, target);
        end
        m_priv = target;
        @(posedge CLK); #1;
        n_checks++;
        if (bus.insert_priv_pc !== 1'b0 || bus.trap_flush !== 1'b0 || bus.trap_stall !== 1'b0 ||
            bus.priv_pc !== m_priv || bus.mcause !== m_mcause || bus.mepc !== m_mepc) begin
            n_fail++;
            $display("FAIL %s after: insert=%b flush=%b stall=%b priv_pc=%h mcause=%h mepc=%h required 0 0 0 %h %h %h",
                     name, bus.insert_priv_pc, bus.trap_flush, bus.trap_stall, bus.priv_pc,
                     bus.mcause, bus.mepc, m_priv, m_mcause, m_mepc);
        end
    endtask

    task automatic check_reset_values(input string name);
        n_checks++;
        if (bus.trap_stall !== 1'b0 || bus.insert_priv_pc !== 1'b0 || bus.trap_flush !== 1'b0 ||
            bus.priv_pc !== 32'h0 || bus.mtvec !== 32'h0000_0100 || bus.mepc !== 32'h0 ||
            bus.mcause !== 32'h0 || bus.mtval !== 32'h0) begin
            n_fail++;
            $display("FAIL %s: stall=%b insert=%b flush=%b priv_pc=%h mtvec=%h mepc=%h mcause=%h mtval=%h required all zero, mtvec=00000100",
                     name, bus.trap_stall, bus.insert_priv_pc, bus.trap_flush, bus.priv_pc,
                     bus.mtvec, bus.mepc, bus.mcause, bus.mtval);
        end
    endtask

    task automatic test_reset();
        nRST = 0;
        drive_ev(ev_zero());
        bus.i_mem_busy = 0; bus.d_mem_busy = 0; bus.csr_wr_mtvec = 0;
        model_reset();
        #13;
        check_reset_values("reset");
        #10 nRST = 1;
        @(posedge CLK); #1;
        check_reset_values("reset_release");
    endtask

    task automatic test_illegal();
        ev_t e = ev_zero();
        e.illegal_insn = 1; e.token_ex = 1; e.epc_e = 32'h0000_0408; e.badaddr_e = 32'hDEAD_BEEF;
        do_event("illegal", e, 0, 0, 0, 0, 0);
    endtask

    task automatic test_mal_load_drain();
        ev_t e = ev_zero();
        e.mal_l = 1; e.token_ex = 1; e.epc_e = 32'h0000_0220; e.badaddr_e = 32'h0000_2003;
        do_event("mal_l_drain", e, 4, 0, 0, 0, 0);
        do_event("mal_l_ibusy", e, 2, 1, 0, 0, 1);
    endtask

    task automatic test_priority();
        ev_t e = ev_zero();
        e.mal_insn = 1; e.fault_s = 1; e.token_ex = 1;
        e.epc_f = 32'h0000_3001; e.epc_e = 32'h0000_2FFC;
        e.badaddr_f = 32'h0000_3001; e.badaddr_e = 32'h0000_7777;
        do_event("prio_exec_wins", e, 0, 0, 0, 0, 0);
        e.token_ex = 0;
        do_event("prio_fetch_only", e, 1, 0, 0, 0, 0);
        e = ev_zero();
        e.fault_insn = 1; e.mispredict = 1; e.epc_f = 32'h0000_4444;
        do_event("fetch_squashed", e, 0, 0, 0, 0, 0);
    endtask

    task automatic test_mret();
        ev_t e = ev_zero();
        csr_write(0, 32'h0000_0555);
        e.ret = 1; e.token_ex = 1;
        do_event("mret", e, 0, 0, 0, 0, 0);
        e.env_m = 1; e.epc_e = 32'h0000_0A00;
        do_event("ret_env_m", e, 0, 0, 0, 0, 0);
    endtask

    task automatic test_csr_interactions();
        ev_t e = ev_zero();
        e.breakpoint = 1; e.token_ex = 1; e.epc_e = 32'h0000_1235; e.badaddr_e = 32'h0000_1235;
        e.csr_wr_mepc = 1; e.csr_wdata = 32'hFFFF_0000;
        do_event("capture_over_mepc_wr", e, 0, 0, 1, 32'h0000_8003, 0);
        e.csr_wr_mepc = 0;
        do_event("mtvec_wr_in_drain", e, 3, 0, 1, 32'h0000_9007, 0);
    endtask

    task automatic test_reset_mid();
        ev_t e = ev_zero();
        e.fault_l = 1; e.token_ex = 1; e.epc_e = 32'h0000_5000; e.badaddr_e = 32'h0000_5004;
        drive_ev(e);
        bus.d_mem_busy = 1;
        @(posedge CLK); #1;
        drive_ev(ev_zero());
        n_checks++;
        if (bus.trap_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_drain: stall=%b required 1", bus.trap_stall);
        end
        #2 nRST = 0;
        model_reset();
        #1 check_reset_values("reset_mid_async");
        bus.d_mem_busy = 0;
        #3 nRST = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            n_checks++;
            if (bus.insert_priv_pc !== 1'b0 || bus.trap_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_no_insert: insert=%b stall=%b required 0 0",
                         bus.insert_priv_pc, bus.trap_stall);
            end
        end
    endtask

    task automatic test_random();
        ev_t e;
        for (int n = 0; n < 40; n++) begin
            e = ev_zero();
            e.token_ex = $urandom_range(0, 1); e.mispredict = ($urandom_range(0, 3) == 0);
            e.fault_insn = ($urandom_range(0, 5) == 0); e.mal_insn = ($urandom_range(0, 5) == 0);
            e.illegal_insn = ($urandom_range(0, 7) == 0); e.breakpoint = ($urandom_range(0, 7) == 0);
            e.env_m = ($urandom_range(0, 7) == 0); e.mal_l = ($urandom_range(0, 7) == 0);
            e.mal_s = ($urandom_range(0, 7) == 0); e.fault_l = ($urandom_range(0, 7) == 0);
            e.fault_s = ($urandom_range(0, 7) == 0); e.ret = ($urandom_range(0, 3) == 0);
            e.csr_wr_mepc = ($urandom_range(0, 3) == 0); e.csr_wdata = $urandom;
            e.epc_f = $urandom; e.epc_e = $urandom; e.badaddr_f = $urandom; e.badaddr_e = $urandom;
            do_event("random", e, $urandom_range(0, 4), $urandom_range(0, 1),
                     ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 1));
        end
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_mal_load_drain();
        test_priority();
        test_mret();
        test_csr_interactions();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tspp_trap_sequencer.md
Name: tspp_trap_sequencer

Overview:
- Sequences traps and MRET for the two-stage pipeline.
- Consumes the fetch- and execute-stage exception flags, EPCs, bad addresses and the ret flag.
- Captures mepc, mcause and mtval, and waits for in-flight memory traffic to drain.
- Drives the hazard unit's priv_pc / insert_priv_pc vector-insertion request, plus a stall and a flush request for the IF/EX latch.

Parameters:
- MTVEC_RST, 32'h0000_0100, reset value of mtvec (bits [1:0] forced to 0).
- MEPC_RST, 32'h0000_0000, reset value of mepc.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- token_ex  in  1  execute stage holds a valid instruction
- mispredict  in  1  execute resolved a mispredict this cycle (fetch slot is wrong-path)
- fault_insn, mal_insn  in  1 each  fetch-stage exceptions
- illegal_insn, breakpoint, env_m, mal_l, mal_s, fault_l, fault_s  in  1 each  execute-stage exceptions
- ret  in  1  MRET in execute
- epc_f, epc_e  in  32  PC of faulting fetch / execute instruction
- badaddr_f, badaddr_e  in  32  faulting address
- i_mem_busy, d_mem_busy  in  1  memory transactions outstanding
- csr_wr_mtvec, csr_wr_mepc  in  1 each  CSR write strobes
- csr_wdata  in  32  CSR write data
- priv_pc  out  32  target PC (mtvec or mepc)
- insert_priv_pc  out  1  one-cycle redirect request
- trap_stall  out  1  freeze IF/EX while draining
- trap_flush  out  1  flush IF/EX latch
- mtvec, mepc, mcause, mtval  out  32 each  CSR read values

Behaviour:
- Reset (nRST=0, asynchronous):
  - state=IDLE; all 1-bit outputs 0; priv_pc=0.
  - mtvec=MTVEC_RST; mepc=MEPC_RST; mcause=0; mtval=0.
- Execute exceptions are qualified by token_ex=1. Priority and mcause code, highest first:
  - illegal_insn 2, breakpoint 3, env_m 11, mal_l 4, mal_s 6, fault_l 5, fault_s 7.
- Fetch exceptions are considered only if there is no qualified execute exception and mispredict=0. Priority: mal_insn 0, then fault_insn 1.
- Capture happens in IDLE on the detection cycle and registers at the next edge:
  - execute trap: mepc=epc_e&~1, mtval=badaddr_e.
  - fetch trap: mepc=epc_f&~1, mtval=badaddr_f.
  - mtval is 0 for illegal_insn and env_m.
  - mcause[31]=0 always.
- ret&token_ex in IDLE with no exception starts the MRET path. CSRs are unchanged; the target is mepc.
- Exception together with ret: the exception wins and ret is dropped.
- FSM states IDLE, DRAIN, INSERT:
  - IDLE → DRAIN on trap/MRET start.
  - DRAIN holds while i_mem_busy|d_mem_busy, then goes to INSERT. DRAIN lasts at least 1 cycle.
  - INSERT → IDLE unconditionally after 1 cycle.
- Outputs per state:
  - trap_stall=1 in DRAIN.
  - In INSERT: insert_priv_pc=1, trap_flush=1, priv_pc = mtvec (trap) or mepc (MRET), with the target selected by a registered is_mret flag.
  - Outside INSERT, priv_pc holds its last value.
- New exceptions or ret during DRAIN/INSERT are ignored (the pipeline is frozen or flushed).
- CSR writes:
  - csr_wr_mtvec: mtvec={csr_wdata[31:2],2'b00}.
  - csr_wr_mepc: mepc={csr_wdata[31:1],1'b0}.
  - A trap capture in the same cycle overrides a CSR write to mepc.
  - A CSR write to mtvec during DRAIN takes effect before INSERT and is used as the target.
- Reset mid-sequence returns to IDLE immediately with no insert pulse.

Optional Feature:
- Macro: TSPP_TRAP_TVAL_EN.
- Defined: mtval captured as described above.
- Undefined: mtval register removed; output tied to 32'h0. Sequencing is otherwise identical.

Decomposition:
- rv32i_types_pkg (existing): word_t.
- Machine-mode package:
  - ex_cause_t enum (codes above);
  - trap_state_t enum {IDLE, DRAIN, INSERT}.
- One combinational sub-module, tspp_trap_prio_enc: flags + token_ex + mispredict → valid, cause, from_fetch.

Test Plan:
- illegal_insn=1, token_ex=1, epc_e=32'h0000_0408, memories idle → mcause=2, mepc=0x408, mtval=0, then:
  - trap_stall=1 for 1 cycle;
  - insert_priv_pc=1 with priv_pc=0x100 for exactly 1 cycle.
- mal_l=1, badaddr_e=0x2003, with d_mem_busy=1 for 4 cycles → trap_stall=1 for 4 cycles, then INSERT; mcause=4, mtval=0x2003.
- Fetch and execute priority:
  - mal_insn=1 and fault_s=1 with token_ex=1 → mcause=7 (execute wins).
  - Same with token_ex=0 → mcause=0, mepc=epc_f.
- fault_insn=1 with mispredict=1 → no trap, state stays IDLE.
- Write mepc=0x0000_0555, then ret&token_ex → mepc reads 0x554; INSERT has priv_pc=0x554; mcause unchanged.
- ret+env_m together → trap path (mcause=11, target mtvec). Separately, assert nRST=0 during DRAIN → outputs reset asynchronously, no insert pulse.
